// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the data-memory bus
// served by dmem_arbiter. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives requests and models memory.
interface dmem_arbiter_if;
  // requester port 0
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [2:0]  p0_rw_type;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;
  // requester port 1
  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [2:0]  p1_rw_type;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;
  // data-memory bus
  logic        mem_w_en;
  logic        mem_r_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_rw_type;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  // status
  logic        busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_rw_type, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_rw_type, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_w_en, mem_r_en, mem_addr, mem_rw_type, mem_din,
    input  mem_dout,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_rw_type, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_rw_type, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_w_en, mem_r_en, mem_addr, mem_rw_type, mem_din,
    output mem_dout,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single data
// memory. Each access takes a fixed three cycles (IDLE -> ACCESS -> RESP);
// the winning request is latched on the grant edge, so requester fields are
// ignored until the next grant. Misaligned or illegal accesses never touch
// memory and complete with err set and rdata zero.
module dmem_arbiter #(
  parameter logic RESET_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Size 11 is illegal; halves need addr[0]=0; words need addr[1:0]=00.
  function automatic logic access_err(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  state_t      state_r;
  logic        prio_r;
  logic        gnt_port_r;
  logic        we_r;
  logic        err_r;
  logic [31:0] addr_r;
  logic [2:0]  rw_type_r;
  logic [31:0] wdata_r;
  logic        mem_w_en_r;
  logic        mem_r_en_r;
  logic        busy_r;
  logic        p0_ack_r;
  logic        p0_err_r;
  logic [31:0] p0_rdata_r;
  logic        p1_ack_r;
  logic        p1_err_r;
  logic [31:0] p1_rdata_r;

  logic        gnt_valid_s;
  logic        gnt_port_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [2:0]  sel_rw_type_s;
  logic [31:0] sel_wdata_s;
  logic        sel_err_s;
  logic [31:0] resp_s;

  // Choose the port to serve (lone requester, else the priority pointer)
  // and mux its fields; the error flag is derived from exactly the fields
  // that get latched.
  always_comb begin
    gnt_valid_s = bus.p0_req | bus.p1_req;
    if (bus.p0_req && bus.p1_req) begin
      gnt_port_s = prio_r;
    end else if (bus.p1_req) begin
      gnt_port_s = 1'b1;
    end else begin
      gnt_port_s = 1'b0;
    end
    if (gnt_port_s) begin
      sel_we_s      = bus.p1_we;
      sel_addr_s    = bus.p1_addr;
      sel_rw_type_s = bus.p1_rw_type;
      sel_wdata_s   = bus.p1_wdata;
    end else begin
      sel_we_s      = bus.p0_we;
      sel_addr_s    = bus.p0_addr;
      sel_rw_type_s = bus.p0_rw_type;
      sel_wdata_s   = bus.p0_wdata;
    end
    sel_err_s = access_err(sel_addr_s[1:0], sel_rw_type_s[1:0]);
  end

  // Response data: memory read data for a good load, zero for stores and errors.
  always_comb begin
    if (we_r || err_r) begin
      resp_s = 32'd0;
    end else begin
      resp_s = bus.mem_dout;
    end
  end

  // Access FSM with all bus and requester outputs registered; the async
  // reset aborts any in-flight access and drops the memory enables at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      prio_r     <= RESET_PRIO;
      gnt_port_r <= 1'b0;
      we_r       <= 1'b0;
      err_r      <= 1'b0;
      addr_r     <= 32'd0;
      rw_type_r  <= 3'd0;
      wdata_r    <= 32'd0;
      mem_w_en_r <= 1'b0;
      mem_r_en_r <= 1'b0;
      busy_r     <= 1'b0;
      p0_ack_r   <= 1'b0;
      p0_err_r   <= 1'b0;
      p0_rdata_r <= 32'd0;
      p1_ack_r   <= 1'b0;
      p1_err_r   <= 1'b0;
      p1_rdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            state_r    <= ACCESS;
            gnt_port_r <= gnt_port_s;
            prio_r     <= ~gnt_port_s;
            we_r       <= sel_we_s;
            err_r      <= sel_err_s;
            addr_r     <= sel_addr_s;
            rw_type_r  <= sel_rw_type_s;
            wdata_r    <= sel_wdata_s;
            mem_w_en_r <= sel_we_s & ~sel_err_s;
            mem_r_en_r <= ~sel_we_s & ~sel_err_s;
            busy_r     <= 1'b1;
          end
        end
        ACCESS: begin
          state_r    <= RESP;
          mem_w_en_r <= 1'b0;
          mem_r_en_r <= 1'b0;
          if (gnt_port_r) begin
            p1_ack_r   <= 1'b1;
            p1_err_r   <= err_r;
            p1_rdata_r <= resp_s;
          end else begin
            p0_ack_r   <= 1'b1;
            p0_err_r   <= err_r;
            p0_rdata_r <= resp_s;
          end
        end
        RESP: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          p0_ack_r   <= 1'b0;
          p0_err_r   <= 1'b0;
          p0_rdata_r <= 32'd0;
          p1_ack_r   <= 1'b0;
          p1_err_r   <= 1'b0;
          p1_rdata_r <= 32'd0;
        end
        default: begin
          state_r    <= IDLE;
          mem_w_en_r <= 1'b0;
          mem_r_en_r <= 1'b0;
          busy_r     <= 1'b0;
          p0_ack_r   <= 1'b0;
          p1_ack_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_w_en    = mem_w_en_r;
  assign bus.mem_r_en    = mem_r_en_r;
  assign bus.mem_addr    = addr_r;
  assign bus.mem_rw_type = rw_type_r;
  assign bus.mem_din     = wdata_r;
  assign bus.busy        = busy_r;
  assign bus.p0_ack      = p0_ack_r;
  assign bus.p0_err      = p0_err_r;
  assign bus.p0_rdata    = p0_rdata_r;
  assign bus.p1_ack      = p1_ack_r;
  assign bus.p1_err      = p1_err_r;
  assign bus.p1_rdata    = p1_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized two-port traffic.
// Expected responses come from a byte-level memory model and are queued per
// port at issue time; a negedge monitor pops and compares on every ack.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.RESET_PRIO(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          issue;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          wen_cnt  = 0;
  logic [31:0] shadow  [0:63];
  logic [31:0] dev_mem [0:63];
  logic        pre_done = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    else if (i == 8) return 32'h0000_8000;
    else return (32'(i) * 32'h0103_0507) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- memory device seen by the DUT ----------------
  function automatic logic [31:0] dev_read(input logic [31:0] w, input logic [1:0] off, input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (t[1:0])
      2'b00:   return t[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return t[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] dev_merge(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (t[1:0])
      2'b00:   r[8*off +: 8] = d[7:0];
      2'b01:   r[16*off[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb bus.mem_dout = dev_read(dev_mem[bus.mem_addr[7:2]], bus.mem_addr[1:0], bus.mem_rw_type);

  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= init_word(i);
      pre_done <= 1'b1;
    end else if (bus.mem_w_en) begin
      dev_mem[bus.mem_addr[7:2]] <= dev_merge(dev_mem[bus.mem_addr[7:2]], bus.mem_addr[1:0],
                                              bus.mem_rw_type, bus.mem_din);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_w_en) wen_cnt <= wen_cnt + 1;

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic logic ref_err(input int unsigned a, input logic [2:0] t);
    return (t[1:0] == 2'b11) || (t[1:0] == 2'b01 && a % 2 != 0) || (t[1:0] == 2'b10 && a % 4 != 0);
  endfunction

  function automatic longint unsigned lane_of(input logic [2:0] t);
    if (t[1:0] == 2'b00) return 64'd256;
    else if (t[1:0] == 2'b01) return 64'd65536;
    else return 64'h1_0000_0000;
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned a, input logic [2:0] t);
    longint unsigned w, v, lane;
    lane = lane_of(t);
    w = 64'(shadow[a / 4]);
    v = (w >> (8 * (a % 4))) % lane;
    if (!t[2] && lane < 64'h1_0000_0000 && v >= lane / 2) v = v + (64'h1_0000_0000 - lane);
    return v[31:0];
  endfunction

  task automatic ref_store(input int unsigned a, input logic [2:0] t, input logic [31:0] d);
    longint unsigned w, lane, old;
    int sh;
    lane = lane_of(t);
    sh   = 8 * int'(a % 4);
    w    = 64'(shadow[a / 4]);
    old  = (w >> sh) % lane;
    w    = w - (old << sh) + ((64'(d) % lane) << sh);
    shadow[a / 4] = w[31:0];
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int p, input logic req, input logic we, input logic [31:0] a,
                       input logic [2:0] t, input logic [31:0] d);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_rw_type = t; bus.p0_wdata = d;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_rw_type = t; bus.p1_wdata = d;
    end
  endtask

  task automatic start_req(input int p, input logic we, input logic [31:0] a,
                           input logic [2:0] t, input logic [31:0] d);
    exp_t e;
    e.err   = ref_err(a, t);
    e.issue = cyc;
    e.rdata = (e.err || we) ? 32'd0 : ref_load(a, t);
    if (we && !e.err) ref_store(a, t, d);
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
    drive(p, 1'b1, we, a, t, d);
  endtask

  task automatic wait_ack(input int p, output int c, output logic err, output logic [31:0] rd);
    c = -1; err = 1'b0; rd = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((p == 0 && bus.p0_ack) || (p == 1 && bus.p1_ack)) begin
        c   = cyc;
        err = (p == 0) ? bus.p0_err : bus.p1_err;
        rd  = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
        break;
      end
    end
    check((p == 0) ? "p0_ack_arrived" : "p1_ack_arrived", 64'(c >= 0), 64'd1);
  endtask

  task automatic rand_port(input int p);
    int c, gap, r;
    logic e, we;
    logic [31:0] rd, a, d;
    logic [2:0] t;
    for (int k = 0; k < 40; k++) begin
      gap = int'($urandom_range(0, 3));
      if (gap != 0) begin
        drive(p, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
        repeat (gap) @(negedge clk);
      end
      r  = int'($urandom_range(0, 7));
      t  = {1'($urandom_range(0, 1)), (r < 7) ? 2'(r % 3) : 2'b11};
      we = 1'($urandom_range(0, 1));
      a  = (p == 0) ? 32'($urandom_range(0, 127)) : 32'($urandom_range(128, 255));
      d  = $urandom;
      start_req(p, we, a, t, d);
      wait_ack(p, c, e, rd);
    end
    drive(p, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_ack(input int p, input logic err, input logic [31:0] rd);
    exp_t e;
    int   sz, lat;
    sz = (p == 0) ? q0.size() : q1.size();
    check((p == 0) ? "p0_ack_expected" : "p1_ack_expected", 64'(sz != 0), 64'd1);
    if (sz != 0) begin
      if (p == 0) e = q0.pop_front();
      else e = q1.pop_front();
      lat = cyc - e.issue;
      check((p == 0) ? "p0_sb_err" : "p1_sb_err", 64'(err), 64'(e.err));
      check((p == 0) ? "p0_sb_rdata" : "p1_sb_rdata", 64'(rd), 64'(e.rdata));
      check((p == 0) ? "p0_sb_latency" : "p1_sb_latency", 64'(lat >= 2 && lat <= 6), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    check("ack_exclusive", 64'(bus.p0_ack & bus.p1_ack), 64'd0);
    check("wr_rd_exclusive", 64'(bus.mem_w_en & bus.mem_r_en), 64'd0);
    if (bus.p0_ack) mon_ack(0, bus.p0_err, bus.p0_rdata);
    else check("p0_quiet", {31'd0, bus.p0_err, bus.p0_rdata}, 64'd0);
    if (bus.p1_ack) mon_ack(1, bus.p1_err, bus.p1_rdata);
    else check("p1_quiet", {31'd0, bus.p1_err, bus.p1_rdata}, 64'd0);
  end

  // ---------------- main sequence ----------------
  initial begin
    int c, c0a, c0b, c1a, c1b, n0, w0, prev, mism;
    logic e;
    logic [31:0] rd;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    repeat (2) @(negedge clk);
    check("rst_ctrl", {57'd0, bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.busy,
                       bus.mem_w_en, bus.mem_r_en}, 64'd0);
    check("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 64'd0);
    check("rst_mem_bus", {bus.mem_addr, bus.mem_din}, 64'd0);
    check("rst_mem_type", 64'(bus.mem_rw_type), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // lone word load from 0x10
    n0 = cyc; w0 = wen_cnt;
    start_req(0, 1'b0, 32'h10, 3'b010, 32'd0);
    @(negedge clk);
    check("access_busy", 64'(bus.busy), 64'd1);
    check("access_enables", {62'd0, bus.mem_r_en, bus.mem_w_en}, 64'd2);
    check("access_addr", 64'(bus.mem_addr), 64'h10);
    check("access_type", 64'(bus.mem_rw_type), 64'd2);
    wait_ack(0, c, e, rd);
    check("ld_latency", 64'(c - n0), 64'd2);
    check("ld_rdata", 64'(rd), 64'hDEAD_BEEF);
    check("ld_err", 64'(e), 64'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("ld_no_wen", 64'(wen_cnt - w0), 64'd0);

    // byte loads at 0x21, sign- then zero-extended
    n0 = cyc;
    start_req(0, 1'b0, 32'h21, 3'b000, 32'd0);
    wait_ack(0, c, e, rd);
    check("lb_latency", 64'(c - n0), 64'd2);
    check("lb_sext", 64'(rd), 64'hFFFF_FF80);
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);
    start_req(0, 1'b0, 32'h21, 3'b100, 32'd0);
    wait_ack(0, c, e, rd);
    check("lbu_zext", 64'(rd), 64'h0000_0080);
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);

    // misaligned half store from p1
    w0 = wen_cnt;
    start_req(1, 1'b1, 32'h13, 3'b001, 32'h1234);
    wait_ack(1, c, e, rd);
    check("sh_mis_err", 64'(e), 64'd1);
    check("sh_mis_rdata", 64'(rd), 64'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);
    check("sh_mis_no_wen", 64'(wen_cnt - w0), 64'd0);
    check("sh_mis_mem", 64'(dev_mem[4]), 64'hDEAD_BEEF);

    // p0 held continuously: one ack every 3 cycles
    n0 = cyc;
    start_req(0, 1'b0, 32'h10, 3'b010, 32'd0);
    wait_ack(0, prev, e, rd);
    check("held_first", 64'(prev - n0), 64'd2);
    for (int k = 0; k < 4; k++) begin
      start_req(0, 1'b0, 32'h10, 3'b010, 32'd0);
      wait_ack(0, c, e, rd);
      check("held_period", 64'(c - prev), 64'd3);
      prev = c;
    end
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(negedge clk);

    // reset pulse in the middle of a word store's ACCESS cycle
    w0 = wen_cnt;
    drive(0, 1'b1, 1'b1, 32'h40, 3'b010, 32'hCAFE_F00D);
    @(posedge clk);
    @(negedge clk);
    check("abort_pre", {62'd0, bus.mem_w_en, bus.busy}, 64'd3);
    #1 rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    #1;
    check("abort_wen_async", 64'(bus.mem_w_en), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_bus", {bus.mem_addr, bus.mem_din}, 64'd0);
    #1 rst_n = 1'b1;

    // both ports request together right after reset release
    n0 = cyc;
    fork
      begin
        start_req(0, 1'b0, 32'h10, 3'b010, 32'd0);
        wait_ack(0, c0a, e, rd);
        start_req(0, 1'b0, 32'h10, 3'b010, 32'd0);
        wait_ack(0, c0b, e, rd);
        drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      end
      begin
        start_req(1, 1'b0, 32'h84, 3'b010, 32'd0);
        wait_ack(1, c1a, e, rd);
        start_req(1, 1'b0, 32'h84, 3'b010, 32'd0);
        wait_ack(1, c1b, e, rd);
        drive(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      end
    join
    check("both_p0_first", 64'(c0a - n0), 64'd2);
    check("both_p1_second", 64'(c1a - n0), 64'd5);
    check("both_p0_again", 64'(c0b - n0), 64'd8);
    check("both_p1_again", 64'(c1b - n0), 64'd11);
    check("abort_no_write", 64'(wen_cnt - w0), 64'd0);
    check("abort_mem", 64'(dev_mem[16]), 64'(shadow[16]));
    @(negedge clk);

    // randomized two-port traffic, each port in its own address half
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (8) @(negedge clk);

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    mism = 0;
    for (int i = 0; i < 64; i++) if (dev_mem[i] !== shadow[i]) mism++;
    check("mem_final", 64'(mism), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: RESET_PRIO, default 0; port given priority on the first contested arbitration after reset (0 = p0, 1 = p1).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 p0_req / p1_req  in  1  access request; held high with fields stable until the matching ack.
REQ-005 p0_we / p1_we  in  1  1 = store, 0 = load.
REQ-006 p0_addr / p1_addr  in  32  byte address.
REQ-007 p0_rw_type / p1_rw_type  in  3  [1:0] size: 00 byte, 01 half, 10 word, 11 illegal; [2] load zero-extend.
REQ-008 p0_wdata / p1_wdata  in  32  store data, LSB-aligned.
REQ-009 p0_ack / p1_ack  out  1  one-cycle completion pulse.
REQ-010 p0_err / p1_err  out  1  misaligned or illegal access; valid only with the matching ack.
REQ-011 p0_rdata / p1_rdata  out  32  load result; valid only with the matching ack.
REQ-012 mem_w_en  out  1  data-memory write enable.
REQ-013 mem_r_en  out  1  data-memory read enable.
REQ-014 mem_addr  out  32  data-memory address.
REQ-015 mem_rw_type  out  3  data-memory access type.
REQ-016 mem_din  out  32  data-memory write data.
REQ-017 mem_dout  in  32  data-memory read data; combinational from mem_addr and mem_rw_type.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any req is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-020 In IDLE with exactly one req high, the block SHALL grant that port.
REQ-021 In IDLE with both reqs high, the block SHALL grant the port named by the priority pointer.
REQ-022 On each grant the priority pointer SHALL flip to the other port (round-robin).
REQ-023 On the IDLE->ACCESS edge, the block SHALL latch the granted port id, we, addr, rw_type and wdata into internal registers.
REQ-024 Latched requester fields SHALL be ignored until the next grant.
REQ-025 Error SHALL be computed from the latched fields.
- rw_type[1:0]=11 is an error.
- Half access with addr[0]=1 is an error.
- Word access with addr[1:0]!=00 is an error.
REQ-026 In ACCESS, mem_addr, mem_rw_type and mem_din SHALL equal the latched values.
- mem_w_en = we & ~err.
- mem_r_en = ~we & ~err.
REQ-027 In any state other than ACCESS, mem_w_en and mem_r_en SHALL be 0; mem_addr, mem_rw_type and mem_din hold their latched values.
REQ-028 At the end of ACCESS, the block SHALL register mem_dout into the response register.
- For a store or an error, the response register SHALL be loaded with 0.
REQ-029 In RESP, the block SHALL assert the granted port's ack for exactly one cycle.
- That port's rdata = response register; that port's err = latched error.
- The other port's ack, err and rdata SHALL be 0.
REQ-030 Latency SHALL be fixed: ack in the 3rd cycle after the cycle in which req is first sampled high in IDLE, for both errors and normal accesses; throughput is one access per 3 cycles.
REQ-031 A req still high in the cycle after its ack SHALL be treated as a new request, arbitrated in IDLE.
REQ-032 A req that rises in ACCESS or RESP SHALL wait and be arbitrated at the next IDLE.
REQ-033 Requests SHALL never be dropped, and neither port can starve: each waits at most one other access.
REQ-034 A store with err SHALL not modify memory (mem_w_en stays 0).

Reset
REQ-035 Asserting rst_n low SHALL immediately force:
- state = IDLE;
- all acks, errs, rdata, mem_w_en and mem_r_en, mem_addr, mem_rw_type, mem_din = 0;
- busy = 0;
- priority pointer = RESET_PRIO.
REQ-036 A reset during ACCESS SHALL abort the access: mem_w_en drops asynchronously, no ack is issued, and the requester must re-request.
REQ-037 After rst_n is released, the first grant SHALL occur on the first posedge at which rst_n is sampled high.

Verification
REQ-038 p0 lone word load from addr 0x10, memory word 0xDEADBEEF -> p0_ack in cycle 3, p0_rdata=0xDEADBEEF, p0_err=0, mem_w_en never high.
REQ-039 p0 and p1 both request in the same cycle after reset (RESET_PRIO=0) -> p0 acked first, p1 acked 3 cycles later; both still held -> p0 granted next.
REQ-040 p1 half store, addr 0x13, wdata 0x1234 -> p1_ack with p1_err=1, mem_w_en stays 0 for the whole transaction, memory unchanged.
REQ-041 p0 byte load, rw_type 000, addr 0x21, memory word 0x0000_8000 -> p0_rdata=0xFFFFFF80; same access with rw_type 100 -> 0x00000080.
REQ-042 rst_n pulsed low during ACCESS of a p0 word store -> mem_w_en falls without waiting for clk, no ack, target word unchanged, busy=0.
REQ-043 p0_req held high continuously with p1 idle -> acks every 3 cycles with no gaps beyond the fixed latency.
